// File: rtl/vp_cart_pkg.sv
// -----------------------------------------------------------------------------
// vp_cart_pkg
// Shared types and constants for the Videopac cartridge memory controller.
//   map_t          : cartridge bank-mapping mode (drives the read address decode)
//   state_t        : controller sequencing states
//   SZ_*           : image sizes that select a mapping mode
//   DL_IDX_*       : download-type codes carried in dl_index_i[1:0]
//   classify_size  : size/overflow to mapping mode for ordinary cartridge images
// -----------------------------------------------------------------------------
package vp_cart_pkg;

    typedef enum logic [2:0] {
        MAP_2K   = 3'd0,
        MAP_4K   = 3'd1,
        MAP_8K   = 3'd2,
        MAP_16K  = 3'd3,
        MAP_XROM = 3'd4
    } map_t;

    typedef enum logic [2:0] {
        ST_RST      = 3'd0,
        ST_LOAD     = 3'd1,
        ST_CLASSIFY = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_RUN      = 3'd4
    } state_t;

    localparam logic [14:0] SZ_4K  = 15'h1000;
    localparam logic [14:0] SZ_8K  = 15'h2000;
    localparam logic [14:0] SZ_16K = 15'h4000;

    localparam logic [1:0] DL_IDX_XROM = 2'd2;
    localparam logic [1:0] DL_IDX_FONT = 2'd3;

    // Anything that is not an exact power-of-two image (or that overflowed
    // the 16 KiB window) falls back to the plain 2K layout.
    function automatic map_t classify_size(input logic [14:0] size, input logic ovf);
        map_t m;
        m = MAP_2K;
        if (size == SZ_4K && !ovf) begin
            m = MAP_4K;
        end else if (size == SZ_8K) begin
            m = MAP_8K;
        end else if (size == SZ_16K && !ovf) begin
            m = MAP_16K;
        end
        return m;
    endfunction

endpackage

// File: rtl/vp_cart_ctrl_addr_map.sv
// -----------------------------------------------------------------------------
// vp_cart_addr_map
// Purely combinational console-address to cartridge-ROM-address decode.
// Ports:
//   map    in  3  : current mapping mode (map_t encoding)
//   cart_a in 12  : console cartridge address
//   bs0    in  1  : bank-select 0
//   bs1    in  1  : bank-select 1
//   rom_a  out 14 : ROM byte address
// Build option: VP_XROM_EN adds the flat 4 KiB XROM decode.
// -----------------------------------------------------------------------------
module vp_cart_addr_map
    import vp_cart_pkg::*;
(
    input  logic [2:0]  map,
    input  logic [11:0] cart_a,
    input  logic        bs0,
    input  logic        bs1,
    output logic [13:0] rom_a
);

    // Console address bit 10 selects internal/external space on the real
    // hardware, so the banked modes skip it and splice in the bank selects.
    always_comb begin
        rom_a = {3'b000, cart_a[11], cart_a[9:0]};
        case (map)
            MAP_4K:   rom_a = {2'b00, bs0, cart_a[11], cart_a[9:0]};
            MAP_8K:   rom_a = {1'b0, bs1, bs0, cart_a[11], cart_a[9:0]};
            MAP_16K:  rom_a = {bs1, bs0, cart_a[11:0]};
`ifdef VP_XROM_EN
            MAP_XROM: rom_a = {2'b00, cart_a[11:0]};
`endif
            default:  rom_a = {3'b000, cart_a[11], cart_a[9:0]};
        endcase
    end

endmodule

// File: rtl/vp_cart_ctrl.sv
// -----------------------------------------------------------------------------
// vp_cart_ctrl
// Cartridge memory controller: shares the single-port cartridge ROM between
// host downloads and console reads, sizes each image to pick a bank mapping,
// and holds the console in reset around downloads.
// Parameters:
//   SETTLE_CYCLES : cycles the console stays in reset after a download or
//                   after sys_res_i drops
//   ROM_AW        : ROM address width (mapping decode covers up to 16 KiB)
// Ports:
//   clk_i, res_n_i (async, active low), sys_res_i (sync console reset req)
//   dl_active_i, dl_index_i, dl_wr_i, dl_addr_i, dl_data_i : host download
//   cart_a_i, cart_bs0_i, cart_bs1_i, cart_psen_n_i, cart_cs_n_i : console bus
//   rom_a_o, rom_d_o, rom_we_o, rom_re_o : ROM port
//   chr_a_o, chr_we_o : font RAM write port (data on rom_d_o)
//   console_res_n_o : console reset, low active, released only in RUN
//   map_o, size_o, busy_o : status
// Build option: VP_XROM_EN enables XROM classification and its data-space read.
// -----------------------------------------------------------------------------
module vp_cart_ctrl
    import vp_cart_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int ROM_AW        = 14
) (
    input  logic              clk_i,
    input  logic              res_n_i,
    input  logic              sys_res_i,
    input  logic              dl_active_i,
    input  logic [7:0]        dl_index_i,
    input  logic              dl_wr_i,
    input  logic [24:0]       dl_addr_i,
    input  logic [7:0]        dl_data_i,
    input  logic [11:0]       cart_a_i,
    input  logic              cart_bs0_i,
    input  logic              cart_bs1_i,
    input  logic              cart_psen_n_i,
    input  logic              cart_cs_n_i,
    output logic [ROM_AW-1:0] rom_a_o,
    output logic [7:0]        rom_d_o,
    output logic              rom_we_o,
    output logic              rom_re_o,
    output logic [8:0]        chr_a_o,
    output logic              chr_we_o,
    output logic              console_res_n_o,
    output logic [2:0]        map_o,
    output logic [14:0]       size_o,
    output logic              busy_o
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_reg, state_next;
    map_t             map_reg, map_next;
    logic [CNT_W-1:0] settle_cnt_reg, settle_cnt_next;
    logic [14:0]      size_reg, size_next;
    logic             ovf_reg, ovf_next;
    logic [1:0]       dl_idx_reg, dl_idx_next;
    logic             dl_active_prev_reg;
    logic             console_res_n_reg;

    logic             dl_rise;
    logic             rom_dl;
    logic [13:0]      mapped_a;

    logic             unused_in_bits;

    assign dl_rise = dl_active_i & ~dl_active_prev_reg;
    // Every download type except the font targets the cartridge ROM.
    assign rom_dl  = (dl_idx_reg != DL_IDX_FONT);

`ifdef VP_XROM_EN
    assign unused_in_bits = ^dl_index_i[7:2];
`else
    assign unused_in_bits = ^{dl_index_i[7:2], cart_cs_n_i};
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            state_reg          <= ST_RST;
            map_reg            <= MAP_2K;
            settle_cnt_reg     <= '0;
            size_reg           <= '0;
            ovf_reg            <= 1'b0;
            dl_idx_reg         <= 2'd0;
            // Pretend the line was already high so a download still active
            // when reset releases is not mistaken for a new one.
            dl_active_prev_reg <= 1'b1;
            console_res_n_reg  <= 1'b0;
        end else begin
            state_reg          <= state_next;
            map_reg            <= map_next;
            settle_cnt_reg     <= settle_cnt_next;
            size_reg           <= size_next;
            ovf_reg            <= ovf_next;
            dl_idx_reg         <= dl_idx_next;
            dl_active_prev_reg <= dl_active_i;
            // Follows the next state so it drops on the same edge RUN is left.
            console_res_n_reg  <= (state_next == ST_RUN);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        settle_cnt_next = '0;
        if (dl_rise) begin
            state_next = ST_LOAD;
        end else begin
            case (state_reg)
                ST_RST:      state_next = ST_SETTLE;
                ST_LOAD:     if (!dl_active_i) state_next = ST_CLASSIFY;
                ST_CLASSIFY: state_next = ST_SETTLE;
                ST_SETTLE: begin
                    if (sys_res_i) begin
                        settle_cnt_next = '0;
                    end else if (settle_cnt_reg == CNT_LAST) begin
                        state_next = ST_RUN;
                    end else begin
                        settle_cnt_next = settle_cnt_reg + CNT_W'(1);
                    end
                end
                ST_RUN:      if (sys_res_i) state_next = ST_SETTLE;
                default:     state_next = ST_RST;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Download bookkeeping: index latch, size counter, mapping classify
    // ------------------------------------------------------------------
    always_comb begin
        dl_idx_next = dl_idx_reg;
        size_next   = size_reg;
        ovf_next    = ovf_reg;
        map_next    = map_reg;

        if (dl_rise) begin
            dl_idx_next = dl_index_i[1:0];
            if (dl_index_i[1:0] != DL_IDX_FONT) begin
                size_next = '0;
                ovf_next  = 1'b0;
            end
        end else if (state_reg == ST_LOAD && rom_dl && dl_wr_i) begin
            // Out-of-range bytes are still counted so oversize images
            // are detected rather than silently truncated.
            if (size_reg == SZ_16K) begin
                ovf_next = 1'b1;
            end else begin
                size_next = size_reg + 15'd1;
            end
        end

        if (state_reg == ST_CLASSIFY && rom_dl) begin
`ifdef VP_XROM_EN
            if (dl_idx_reg == DL_IDX_XROM) begin
                map_next = MAP_XROM;
            end else begin
                map_next = classify_size(size_reg, ovf_reg);
            end
`else
            map_next = classify_size(size_reg, ovf_reg);
`endif
        end
    end

    // ------------------------------------------------------------------
    // ROM / font port muxing
    // ------------------------------------------------------------------
    vp_cart_addr_map u_addr_map (
        .map    (map_reg),
        .cart_a (cart_a_i),
        .bs0    (cart_bs0_i),
        .bs1    (cart_bs1_i),
        .rom_a  (mapped_a)
    );

    always_comb begin
        rom_a_o  = '0;
        rom_re_o = 1'b0;
        rom_we_o = 1'b0;
        chr_we_o = 1'b0;
        if (state_reg == ST_LOAD) begin
            rom_a_o = dl_addr_i[ROM_AW-1:0];
            if (rom_dl) begin
                rom_we_o = dl_wr_i & (dl_addr_i[24:ROM_AW] == '0);
            end else begin
                chr_we_o = dl_wr_i & (dl_addr_i[24:9] == '0);
            end
        end else if (state_reg != ST_RST) begin
            // Port stays idle in RST so the ROM sees nothing while in reset.
            rom_a_o  = mapped_a[ROM_AW-1:0];
            rom_re_o = ~cart_psen_n_i;
`ifdef VP_XROM_EN
            if (map_reg == MAP_XROM && !cart_cs_n_i && !cart_bs0_i) begin
                rom_re_o = 1'b1;
            end
`endif
        end
    end

    assign rom_d_o         = dl_data_i;
    assign chr_a_o         = dl_addr_i[8:0];
    assign console_res_n_o = console_res_n_reg;
    assign map_o           = map_reg;
    assign size_o          = size_reg;
    assign busy_o          = (state_reg != ST_RUN);

endmodule

// File: tb/tb_vp_cart_ctrl.sv
module tb_vp_cart_ctrl;

    logic        clk_i = 1'b0;
    logic        res_n_i;
    logic        sys_res_i;
    logic        dl_active_i;
    logic [7:0]  dl_index_i;
    logic        dl_wr_i;
    logic [24:0] dl_addr_i;
    logic [7:0]  dl_data_i;
    logic [11:0] cart_a_i;
    logic        cart_bs0_i;
    logic        cart_bs1_i;
    logic        cart_psen_n_i;
    logic        cart_cs_n_i;
    logic [13:0] rom_a_o;
    logic [7:0]  rom_d_o;
    logic        rom_we_o;
    logic        rom_re_o;
    logic [8:0]  chr_a_o;
    logic        chr_we_o;
    logic        console_res_n_o;
    logic [2:0]  map_o;
    logic [14:0] size_o;
    logic        busy_o;

    vp_cart_ctrl dut (
        .clk_i           (clk_i),
        .res_n_i         (res_n_i),
        .sys_res_i       (sys_res_i),
        .dl_active_i     (dl_active_i),
        .dl_index_i      (dl_index_i),
        .dl_wr_i         (dl_wr_i),
        .dl_addr_i       (dl_addr_i),
        .dl_data_i       (dl_data_i),
        .cart_a_i        (cart_a_i),
        .cart_bs0_i      (cart_bs0_i),
        .cart_bs1_i      (cart_bs1_i),
        .cart_psen_n_i   (cart_psen_n_i),
        .cart_cs_n_i     (cart_cs_n_i),
        .rom_a_o         (rom_a_o),
        .rom_d_o         (rom_d_o),
        .rom_we_o        (rom_we_o),
        .rom_re_o        (rom_re_o),
        .chr_a_o         (chr_a_o),
        .chr_we_o        (chr_we_o),
        .console_res_n_o (console_res_n_o),
        .map_o           (map_o),
        .size_o          (size_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  map;
        logic [11:0] a;
        logic        bs0;
        logic        bs1;
        logic        psen_n;
        logic        cs_n;
        logic [13:0] exp_a;
        logic        exp_re;
    } rd_vec_t;

    localparam int NV = 10;
    rd_vec_t vecs [NV];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One download: raise dl_active, one byte per cycle from address 0,
    // then drop dl_active right after the edge that took the last byte.
    task automatic download(input logic [7:0] idx, input int n,
                            output int we_cnt, output int chr_cnt, output logic last_we);
        we_cnt = 0; chr_cnt = 0; last_we = 1'b0;
        @(posedge clk_i); #1;
        dl_index_i  = idx;
        dl_active_i = 1'b1;
        @(posedge clk_i); #1;
        for (int i = 0; i < n; i++) begin
            dl_wr_i   = 1'b1;
            dl_addr_i = 25'(i);
            dl_data_i = 8'(i);
            #1;
            if (rom_we_o) we_cnt++;
            if (chr_we_o) chr_cnt++;
            last_we = rom_we_o;
            @(posedge clk_i); #1;
        end
        dl_wr_i     = 1'b0;
        dl_active_i = 1'b0;
    endtask

    // Edges until console_res_n_o rises, -1 if not within the budget.
    task automatic wait_release(output int k);
        k = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk_i); #1;
            if (console_res_n_o) begin
                k = c;
                break;
            end
        end
    endtask

    task automatic run_vecs(input logic [2:0] mode);
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].map == mode) begin
                cart_a_i      = vecs[i].a;
                cart_bs0_i    = vecs[i].bs0;
                cart_bs1_i    = vecs[i].bs1;
                cart_psen_n_i = vecs[i].psen_n;
                cart_cs_n_i   = vecs[i].cs_n;
                #1;
                $display("read map=%0d a=0x%03h bs=%b%b -> rom_a=0x%04h re=%b",
                         mode, vecs[i].a, vecs[i].bs1, vecs[i].bs0, rom_a_o, rom_re_o);
                chk($sformatf("rd_addr[%0d]", i), 32'(rom_a_o), 32'(vecs[i].exp_a));
                chk($sformatf("rd_re[%0d]", i), 32'(rom_re_o), 32'(vecs[i].exp_re));
            end
        end
        cart_psen_n_i = 1'b1;
        cart_cs_n_i   = 1'b1;
    endtask

    int   we_cnt, chr_cnt, rel, bad_we;
    logic last_we;

    initial begin
        //          map   a       bs0   bs1   psen  cs    exp_a     re
        vecs[0] = '{3'd0, 12'hFFF, 1'b1, 1'b1, 1'b0, 1'b1, 14'h07FF, 1'b1};
        vecs[1] = '{3'd0, 12'h400, 1'b0, 1'b0, 1'b1, 1'b0, 14'h0000, 1'b0};
        vecs[2] = '{3'd1, 12'h805, 1'b1, 1'b0, 1'b0, 1'b1, 14'h0C05, 1'b1};
        vecs[3] = '{3'd1, 12'h3FF, 1'b0, 1'b1, 1'b1, 1'b1, 14'h03FF, 1'b0};
        vecs[4] = '{3'd1, 12'hC00, 1'b0, 1'b0, 1'b0, 1'b1, 14'h0400, 1'b1};
        vecs[5] = '{3'd2, 12'h805, 1'b1, 1'b1, 1'b0, 1'b1, 14'h1C05, 1'b1};
        vecs[6] = '{3'd2, 12'h2AA, 1'b0, 1'b1, 1'b1, 1'b0, 14'h12AA, 1'b0};
        vecs[7] = '{3'd3, 12'hABC, 1'b0, 1'b1, 1'b0, 1'b1, 14'h2ABC, 1'b1};
        vecs[8] = '{3'd3, 12'hFFF, 1'b1, 1'b1, 1'b1, 1'b0, 14'h3FFF, 1'b0};
        vecs[9] = '{3'd3, 12'h000, 1'b1, 1'b0, 1'b1, 1'b1, 14'h1000, 1'b0};

        res_n_i = 1'b0; sys_res_i = 1'b0; dl_active_i = 1'b0; dl_index_i = 8'd0;
        dl_wr_i = 1'b0; dl_addr_i = '0; dl_data_i = 8'd0; cart_a_i = 12'd0;
        cart_bs0_i = 1'b0; cart_bs1_i = 1'b0; cart_psen_n_i = 1'b1; cart_cs_n_i = 1'b1;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_console", 32'(console_res_n_o), 32'd0);
        chk("rst_map", 32'(map_o), 32'd0);
        chk("rst_size", 32'(size_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd1);
        chk("rst_we", 32'({rom_we_o, chr_we_o, rom_re_o}), 32'd0);
        chk("rst_rom_a", 32'(rom_a_o), 32'd0);
        res_n_i = 1'b1;
        wait_release(rel);
        $display("power-on release after %0d cycles", rel);
        chk("poweron_release", 32'(rel), 32'd17);
        chk("run_busy", 32'(busy_o), 32'd0);

        // 4K cartridge
        download(8'd0, 4096, we_cnt, chr_cnt, last_we);
        wait_release(rel);
        $display("download idx=0 bytes=4096 size=0x%0h map=%0d release=%0d", size_o, map_o, rel);
        chk("4k_release", 32'(rel), 32'd18);
        chk("4k_map", 32'(map_o), 32'd1);
        chk("4k_size", 32'(size_o), 32'h1000);
        chk("4k_we_count", 32'(we_cnt), 32'd4096);
        run_vecs(3'd1);

        // 8K cartridge
        download(8'd1, 8192, we_cnt, chr_cnt, last_we);
        wait_release(rel);
        $display("download idx=1 bytes=8192 size=0x%0h map=%0d release=%0d", size_o, map_o, rel);
        chk("8k_map", 32'(map_o), 32'd2);
        chk("8k_size", 32'(size_o), 32'h2000);
        run_vecs(3'd2);

        // Font download leaves mapping and size alone
        download(8'd3, 512, we_cnt, chr_cnt, last_we);
        wait_release(rel);
        $display("download idx=3 bytes=512 chr_we=%0d rom_we=%0d map=%0d", chr_cnt, we_cnt, map_o);
        chk("font_chr_we", 32'(chr_cnt), 32'd512);
        chk("font_rom_we", 32'(we_cnt), 32'd0);
        chk("font_map", 32'(map_o), 32'd2);
        chk("font_size", 32'(size_o), 32'h2000);
        chk("font_release", 32'(rel), 32'd18);

        // 16K cartridge
        download(8'd0, 16384, we_cnt, chr_cnt, last_we);
        wait_release(rel);
        $display("download idx=0 bytes=16384 size=0x%0h map=%0d", size_o, map_o);
        chk("16k_map", 32'(map_o), 32'd3);
        chk("16k_size", 32'(size_o), 32'h4000);
        run_vecs(3'd3);

        // Async reset in the middle of a download
        @(posedge clk_i); #1;
        dl_index_i = 8'd0; dl_active_i = 1'b1;
        @(posedge clk_i); #1;
        for (int i = 0; i < 3; i++) begin
            dl_wr_i = 1'b1; dl_addr_i = 25'(i);
            @(posedge clk_i); #1;
        end
        dl_addr_i = 25'd3;
        #1;
        chk("abort_pre_we", 32'(rom_we_o), 32'd1);
        #1 res_n_i = 1'b0;
        #1;
        $display("async reset mid-load: we=%b map=%0d size=0x%0h", rom_we_o, map_o, size_o);
        chk("abort_we", 32'(rom_we_o), 32'd0);
        chk("abort_map", 32'(map_o), 32'd0);
        chk("abort_size", 32'(size_o), 32'd0);
        chk("abort_console", 32'(console_res_n_o), 32'd0);
        @(posedge clk_i); #1;
        res_n_i = 1'b1;
        bad_we = 0;
        repeat (4) begin
            @(posedge clk_i); #1;
            if (rom_we_o) bad_we++;
        end
        chk("abort_no_reload", 32'(bad_we), 32'd0);
        chk("abort_size_hold", 32'(size_o), 32'd0);
        dl_wr_i = 1'b0; dl_active_i = 1'b0;
        wait_release(rel);
        chk("abort_release", 32'(rel), 32'd13);

        // Oversize image: 16385 bytes
        download(8'd0, 16385, we_cnt, chr_cnt, last_we);
        wait_release(rel);
        $display("download idx=0 bytes=16385 size=0x%0h map=%0d last_we=%b", size_o, map_o, last_we);
        chk("ovf_size", 32'(size_o), 32'h4000);
        chk("ovf_map", 32'(map_o), 32'd0);
        chk("ovf_last_we", 32'(last_we), 32'd0);
        chk("ovf_we_count", 32'(we_cnt), 32'd16384);
        run_vecs(3'd0);

        // Index 2 image
        download(8'd2, 4096, we_cnt, chr_cnt, last_we);
        wait_release(rel);
        $display("download idx=2 bytes=4096 map=%0d", map_o);
`ifdef VP_XROM_EN
        chk("idx2_map", 32'(map_o), 32'd4);
`else
        chk("idx2_map", 32'(map_o), 32'd1);
`endif

        // Re-trigger during SETTLE
        download(8'd0, 16, we_cnt, chr_cnt, last_we);
        repeat (6) @(posedge clk_i);
        #1;
        chk("retrig_console", 32'(console_res_n_o), 32'd0);
        chk("retrig_busy", 32'(busy_o), 32'd1);
        download(8'd0, 16, we_cnt, chr_cnt, last_we);
        wait_release(rel);
        $display("retrigger: release=%0d size=0x%0h map=%0d", rel, size_o, map_o);
        chk("retrig_release", 32'(rel), 32'd18);
        chk("retrig_size", 32'(size_o), 32'd16);
        chk("retrig_map", 32'(map_o), 32'd0);

        // sys_res held for 3 cycles in RUN
        @(posedge clk_i); #1;
        sys_res_i = 1'b1;
        @(posedge clk_i); #1;
        chk("sysres_console", 32'(console_res_n_o), 32'd0);
        @(posedge clk_i);
        @(posedge clk_i); #1;
        sys_res_i = 1'b0;
        wait_release(rel);
        $display("sys_res pulse: release=%0d", rel);
        chk("sysres_release", 32'(rel), 32'd16);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
